// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH cycles, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic bit_s_c;
    logic bit_c_c;
    logic load_c;

    // Single full-adder cell shared by every bit position.
    always_comb begin
        bit_s_c = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        bit_c_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
        load_c  = start && (state_q != S_RUN);
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                busy_d  = 1'b1;
                carry_d = bit_c_c;
                sum_d   = {bit_s_c, sum_q[WIDTH-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    cout_d  = bit_c_c;
`ifdef SERIAL_ADD_OVF_EN
                    // Carry into the MSB cell XOR carry out of it.
                    ovf_d   = carry_q ^ bit_c_c;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accepted start from IDLE or DONE; ignored while running.
        if (load_c) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed cases plus random operands against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer addition of the operands captured at the accepted start.
    task automatic model(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i, input logic cin_i,
                         output logic [WIDTH-1:0] s_o, output logic c_o, output logic v_o);
        longint unsigned full;
        longint signed   sa, sb, ss;
        full = longint'(a_i) + longint'(b_i) + longint'(cin_i);
        s_o  = WIDTH'(full);
        c_o  = full[WIDTH];
        sa   = longint'($signed(a_i));
        sb   = longint'($signed(b_i));
        ss   = sa + sb + longint'(cin_i);
        v_o  = (ss > ((64'sd1 <<< (WIDTH - 1)) - 1)) || (ss < -(64'sd1 <<< (WIDTH - 1)));
    endtask

    // Issue a one-cycle start at the current negedge; optionally fire a second start mid-run.
    task automatic run_op(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i, input logic cin_i,
                          input int inj_cycle);
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             ev;
        int               n_done;
        model(a_i, b_i, cin_i, es, ec, ev);
        start = 1'b1;
        a = a_i;
        b = b_i;
        cin = cin_i;
        n_done = 0;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
        check("sum_cleared_on_start", 64'(sum), 64'(0));
        check("cout_cleared_on_start", 64'(cout), 64'(0));
        for (int k = 1; k <= int'(WIDTH); k++) begin
            check("busy_run", 64'(busy), 64'(1));
            if (done) n_done++;
            if (k == inj_cycle) begin
                start = 1'b1;
                a = 8'hAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", 64'(done), 64'(1));
        check("busy_in_done", 64'(busy), 64'(0));
        check("sum", 64'(sum), 64'(es));
        check("cout", 64'(cout), 64'(ec));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 64'(ovf), 64'(ev));
`endif
        if (done) n_done++;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("busy_after", 64'(busy), 64'(0));
        check("sum_hold", 64'(sum), 64'(es));
        check("cout_hold", 64'(cout), 64'(ec));
        check("done_count", 64'(n_done), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             ev;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h0F, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'h00, 1'b1, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);
        run_op(8'h10, 8'h20, 1'b0, 3);

        // Hold in IDLE: result must persist.
        repeat (5) @(negedge clk);
        check("idle_hold_sum", 64'(sum), 64'(8'h30));

        // Reset mid-run aborts without a done pulse.
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sum", 64'(sum), 64'(0));
        check("abort_cout", 64'(cout), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(WIDTH) + 2; k++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done | busy), 64'(0));
        end
        run_op(8'h05, 8'h03, 1'b0, 0);

        // Start held high: back-to-back adds with a done every WIDTH+1 cycles.
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        for (int n = 1; n <= 3 * (int'(WIDTH) + 1); n++) begin
            @(negedge clk);
            check("b2b_done", 64'(done), 64'((n % (int'(WIDTH) + 1)) == 0));
            check("b2b_busy", 64'(busy), 64'((n % (int'(WIDTH) + 1)) != 0));
            if (done) check("b2b_sum", 64'(sum), 64'(8'h02));
        end
        start = 1'b0;
        repeat (int'(WIDTH) + 1) @(negedge clk);

        // Random operands, occasionally with an ignored mid-run start.
        for (int t = 0; t < 40; t++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   (($urandom % 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        model(8'h7F, 8'h01, 1'b0, es, ec, ev);
        check("model_sanity_ovf", 64'(ev), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. One single-bit full-adder cell is reused over WIDTH cycles, LSB first. Carry is held in a flip-flop between bits. The block accepts one operand pair per start pulse, reports busy while running, pulses done at completion, and holds the result until the next accepted start. It gives area-constrained designs a WIDTH-bit add without a WIDTH-bit ripple chain.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled on rising clk.
- a  input  WIDTH  operand A, sampled only on an accepted start.
- b  input  WIDTH  operand B, sampled only on an accepted start.
- cin  input  1  carry-in, sampled only on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result; valid from done until the next accepted start.
- cout  output  1  final carry-out; valid with sum.

## Operation
- **State machine**
  - IDLE: start=1 → RUN. Latch a and b into shift registers, carry ← cin, bit counter ← 0, sum ← 0, cout ← 0.
  - RUN: each cycle:
    - s = a_sr[0] ^ b_sr[0] ^ carry;
    - carry ← maj(a_sr[0], b_sr[0], carry);
    - sum ← {s, sum[WIDTH-1:1]};
    - a_sr and b_sr shift right by 1;
    - counter increments.
  - RUN exit: when the counter equals WIDTH-1 on an edge, that bit completes and the state goes to DONE. cout ← the carry produced by that bit.
  - DONE: done=1 for exactly this cycle.
    - start=1 → RUN, same latching as IDLE (back-to-back operation).
    - Otherwise → IDLE.
- **Start handling**
  - start is ignored while in RUN. No queuing, no effect on the running operation.
  - a, b and cin may change freely after the accepted start.
- **Arithmetic**
  - Result is (a + b + cin) mod 2^WIDTH.
  - cout is bit WIDTH of the full sum.
  - Unsigned; no saturation.
- **Reset**
  - While rst=1, immediately: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, shift registers=0.
  - Reset during RUN aborts the operation. No done is produced for it.
  - After rst deasserts, a new start is required.
- **Result holding**
  - sum and cout hold their value in IDLE indefinitely.
  - They are cleared to 0 only by reset or an accepted start.

## Timing
- The accepted start is sampled at edge E0.
- busy=1 from after E0 through the cycle ending at edge E0+WIDTH.
- done=1 in the cycle after edge E0+WIDTH (after the final bit).
- sum and cout are stable at the same time done rises.
- Latency: start to done is WIDTH clock cycles.
- Throughput: one add per WIDTH+1 cycles. With start held high in DONE, throughput is one add per WIDTH+1 cycles with no idle gap.
- busy and done are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf, 1 bit: signed overflow of the WIDTH-bit two's-complement add.
  - ovf is the XOR of the carry into the MSB cell and the carry out of the MSB cell.
  - ovf is captured on the same edge as cout and is valid with sum.
  - ovf resets to 0 and clears to 0 on an accepted start.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, cin=0, one-cycle start → busy for 8 cycles; done pulse 8 cycles after start; sum=0x10, cout=0.
- a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. With SERIAL_ADD_OVF_EN: ovf=0.
- a=0x7F, b=0x01, cin=0 with SERIAL_ADD_OVF_EN → sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- Start pulsed with a=0x10, b=0x20, then a second start with a=0xAA at cycle 3 of RUN → the second start is ignored; sum=0x30, exactly one done.
- rst asserted at cycle 4 of RUN → busy, done, sum and cout go to 0 at once, with no done. A new start with a=0x05, b=0x03 then gives sum=0x08.
- start held high continuously with a=0x01, b=0x01 → done every 9 cycles, sum=0x02 each time, busy low only during the done cycles.
